bullet_pool: RTL and testbench
==============================

Name: bullet_pool

Overview:
- Parametrised multi-shot successor to the single-bullet block.
- Manages NUM_BULLETS independent bullet slots fired from the ship position on the space key, with edge or auto-repeat firing, a fire cooldown and per-slot hit retirement.
- Sits between the keyboard scan-code path and the collision/colour-mapper logic; advances once per frame_clk (vsync-derived frame tick).

Parameters:
- NUM_BULLETS, 4, number of bullet slots (1..8).
- SPEED, 8, upward pixels per frame.
- Y_MIN, 30, topmost playfield Y.
- SIZE, 3, bullet radius, driven on bullet_size.
- COOLDOWN, 6, frames after a launch during which no new launch is allowed (0 = none).
- AUTO_FIRE, 0, 0 = one shot per key press (rising edge), 1 = repeat while held, rate-limited by COOLDOWN.
- KEY_CODE, 8'h2c, fire scan code.

Ports:
- frame_clk, input, 1, the block's only clock; all state updates on its rising edge.
- Reset, input, 1, synchronous, active-low reset.
- game_over, input, 1, high = clear all bullets and block firing.
- start_screen, input, 1, same effect as game_over.
- ship_X, input, 10, launch/park X.
- ship_Y, input, 10, launch/park Y.
- space_key, input, 24, three keycode bytes [23:16],[15:8],[7:0].
- bullet_hit, input, NUM_BULLETS, per-slot hit from collision logic.
- bullet_active, output, NUM_BULLETS, per-slot active flag.
- bullet_X_out, output, 10*NUM_BULLETS, slot i at [10i+9:10i].
- bullet_Y_out, output, 10*NUM_BULLETS, same packing.
- bullet_size, output, 10, constant SIZE.
- fire_pulse, output, 1, high for the one frame in which a launch is registered.
- shots_fired, output, 8, saturating launch count.

Behaviour:
- Reset low at a frame_clk edge clears all state: bullet_active=0, all X/Y outputs=0, fire_pulse=0, shots_fired=0, cooldown=0, key_prev=0.
- Inactive slots park: each frame their X/Y load ship_X/ship_Y.
- key_down = any of the three space_key bytes == KEY_CODE. key_prev registers key_down every frame, including during game_over/start_screen.
- fire_req = AUTO_FIRE ? key_down : (key_down & ~key_prev).
- Launch condition: fire_req & cooldown==0 & ~game_over & ~start_screen & ship_Y > Y_MIN & at least one free slot.
  - A free slot is one whose registered bullet_active=0.
- On launch:
  - The lowest-index free slot gets active=1, X=ship_X, Y=ship_Y.
  - cooldown loads COOLDOWN.
  - fire_pulse=1 for that frame.
  - shots_fired increments, holding at 255.
  - Exactly one launch per frame.
- cooldown decrements by 1 each frame when nonzero.
- An active slot retires when bullet_hit[i]=1 or Y < Y_MIN+SIZE+SPEED (41 by default): active=0, X/Y park. Otherwise Y <= Y-SPEED and X holds.
  - The retire check precedes the subtract, so Y never wraps.
- A slot that retires in a frame is not free for a launch in that same frame; it is eligible the next frame.
- bullet_hit on an inactive slot is ignored.
- game_over or start_screen high:
  - All slots clear to active=0 and park; cooldown forced to 0; no launch.
  - fire_pulse and shots_fired behave as if no launch.
- Pool full: fire_req is dropped, not queued. cooldown is unchanged.
- Reset takes priority over every other input, including mid-flight bullets.
- Outputs are registered; bullet_active and positions reflect state after the latest frame edge.

Test Plan:
- Defaults, ship (320,400), space_key[7:0]=8'h2c for 1 frame → next frame slot0 active at (320,400), fire_pulse=1, shots_fired=1; then Y=392, 384 …; slot0 retires the frame after Y=40 (46 frames after launch).
- AUTO_FIRE=0, key held 20 frames → exactly one launch. AUTO_FIRE=1, key held 20 frames → launches at frames 0,7,14 (COOLDOWN=6) into slots 0,1,2.
- Four edge presses spaced 8 frames apart, then a fifth → slots 0-3 active, fifth press produces no fire_pulse; shots_fired=4.
- With slots 0-3 active, bullet_hit=4'b0010 → slot1 clears the next frame; a press in the hit frame is ignored; a press the following frame fills slot1.
- Bullet in flight, game_over=1 for 1 frame → all bullet_active=0, positions = ship; a key press during game_over does not fire.
- Reset low mid-flight at a frame edge → all outputs 0, shots_fired=0. Reset released with key already held and AUTO_FIRE=0 → fires on that first frame, because key_prev was cleared to 0 by reset.

Source files
------------

// File: rtl/bullet_pool.sv
// Multi-slot bullet manager: launches from the ship on the fire key, flies each
// active slot upward once per frame and retires it on hit or at the top edge.

module bullet_pool_slot #(
    parameter int         SPEED    = 8,
    parameter logic [9:0] RETIRE_Y = 10'd41
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       launch_i,
    input  logic       hit_i,
    input  logic [9:0] ship_x_i,
    input  logic [9:0] ship_y_i,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o
);
    logic       active_q, active_d;
    logic [9:0] x_q, x_d, y_q, y_d;

    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        // Parked slots track the ship, so a launch simply latches active.
        if (clear_i || !active_q) begin
            active_d = launch_i && !clear_i;
            x_d      = ship_x_i;
            y_d      = ship_y_i;
        end else if (hit_i || (y_q < RETIRE_Y)) begin
            active_d = 1'b0;
            x_d      = ship_x_i;
            y_d      = ship_y_i;
        end else begin
            y_d = y_q - 10'(SPEED);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
endmodule

module bullet_pool #(
    parameter int         NUM_BULLETS = 4,
    parameter int         SPEED       = 8,
    parameter int         Y_MIN       = 30,
    parameter int         SIZE        = 3,
    parameter int         COOLDOWN    = 6,
    parameter int         AUTO_FIRE   = 0,
    parameter logic [7:0] KEY_CODE    = 8'h2c
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      game_over,
    input  logic                      start_screen,
    input  logic [9:0]                ship_X,
    input  logic [9:0]                ship_Y,
    input  logic [23:0]               space_key,
    input  logic [NUM_BULLETS-1:0]    bullet_hit,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic [10*NUM_BULLETS-1:0] bullet_X_out,
    output logic [10*NUM_BULLETS-1:0] bullet_Y_out,
    output logic [9:0]                bullet_size,
    output logic                      fire_pulse,
    output logic [7:0]                shots_fired
);
    localparam int         CW       = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [9:0] YMIN_L   = 10'(Y_MIN);
    localparam logic [9:0] RETIRE_Y = 10'(Y_MIN + SIZE + SPEED);

    logic                   key_prev_q;
    logic [CW-1:0]          cd_q, cd_d;
    logic                   pulse_q;
    logic [7:0]             shots_q, shots_d;
    logic                   key_down, fire_req, blocked, launch;
    logic [NUM_BULLETS-1:0] free, sel, launch_vec;

    assign key_down = (space_key[23:16] == KEY_CODE) || (space_key[15:8] == KEY_CODE) ||
                      (space_key[7:0] == KEY_CODE);
    assign fire_req = (AUTO_FIRE != 0) ? key_down : (key_down & ~key_prev_q);
    assign blocked  = game_over | start_screen;
    assign free     = ~bullet_active;
    // Isolate the lowest set bit of the free mask.
    assign sel      = free & (~free + NUM_BULLETS'(1));
    assign launch   = fire_req && (cd_q == '0) && !blocked && (ship_Y > YMIN_L) && (|free);
    assign launch_vec = launch ? sel : '0;

    always_comb begin
        cd_d    = cd_q;
        shots_d = shots_q;
        if (blocked)           cd_d = '0;
        else if (launch)       cd_d = CW'(COOLDOWN);
        else if (cd_q != '0)   cd_d = cd_q - CW'(1);
        if (launch && shots_q != 8'hFF) shots_d = shots_q + 8'd1;
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            key_prev_q <= 1'b0;
            cd_q       <= '0;
            pulse_q    <= 1'b0;
            shots_q    <= '0;
        end else begin
            key_prev_q <= key_down;
            cd_q       <= cd_d;
            pulse_q    <= launch;
            shots_q    <= shots_d;
        end
    end

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_pool_slot #(.SPEED(SPEED), .RETIRE_Y(RETIRE_Y)) u_slot (
            .clk_i   (frame_clk),
            .rst_ni  (Reset),
            .clear_i (blocked),
            .launch_i(launch_vec[i]),
            .hit_i   (bullet_hit[i]),
            .ship_x_i(ship_X),
            .ship_y_i(ship_Y),
            .active_o(bullet_active[i]),
            .x_o     (bullet_X_out[10*i +: 10]),
            .y_o     (bullet_Y_out[10*i +: 10])
        );
    end

    assign bullet_size = 10'(SIZE);
    assign fire_pulse  = pulse_q;
    assign shots_fired = shots_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: edge-fire and auto-fire instances driven in parallel,
// checked each frame against a slot-list model plus literal spot checks.

module tb_bullet_pool;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n, go, ss;
    logic [9:0]    sx, sy;
    logic [23:0]   key;
    logic [NB-1:0] hit;

    logic [NB-1:0]    act_o  [2];
    logic [10*NB-1:0] x_o    [2];
    logic [10*NB-1:0] y_o    [2];
    logic [9:0]       size_o [2];
    logic             pulse_o[2];
    logic [7:0]       shots_o[2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    for (genvar a = 0; a < 2; a++) begin : g_dut
        bullet_pool #(.NUM_BULLETS(NB), .AUTO_FIRE(a)) u_dut (
            .frame_clk   (clk),
            .Reset       (rst_n),
            .game_over   (go),
            .start_screen(ss),
            .ship_X      (sx),
            .ship_Y      (sy),
            .space_key   (key),
            .bullet_hit  (hit),
            .bullet_active(act_o[a]),
            .bullet_X_out(x_o[a]),
            .bullet_Y_out(y_o[a]),
            .bullet_size (size_o[a]),
            .fire_pulse  (pulse_o[a]),
            .shots_fired (shots_o[a])
        );
    end

    // Model: a list of slots per instance, updated from the frame rules.
    bit m_act[2][NB];
    int m_x[2][NB], m_y[2][NB];
    int m_cd[2], m_shots[2];
    bit m_prev[2], m_pulse[2];

    always @(posedge clk) begin : model
        bit kd, req, blk, launch;
        int fidx;
        bit na[NB];
        int nx[NB], ny[NB];
        kd  = (key[23:16] == 8'h2c) || (key[15:8] == 8'h2c) || (key[7:0] == 8'h2c);
        blk = go || ss;
        for (int a = 0; a < 2; a++) begin
            if (!rst_n) begin
                for (int i = 0; i < NB; i++) begin
                    m_act[a][i] <= 0; m_x[a][i] <= 0; m_y[a][i] <= 0;
                end
                m_cd[a] <= 0; m_shots[a] <= 0; m_prev[a] <= 0; m_pulse[a] <= 0;
            end else begin
                req  = (a == 1) ? kd : (kd && !m_prev[a]);
                fidx = -1;
                for (int i = NB - 1; i >= 0; i--) if (!m_act[a][i]) fidx = i;
                launch = req && m_cd[a] == 0 && !blk && int'(sy) > 30 && fidx >= 0;
                for (int i = 0; i < NB; i++) begin
                    if (blk || !m_act[a][i] || hit[i] || m_y[a][i] < 41) begin
                        na[i] = 0; nx[i] = int'(sx); ny[i] = int'(sy);
                    end else begin
                        na[i] = 1; nx[i] = m_x[a][i]; ny[i] = m_y[a][i] - 8;
                    end
                end
                if (launch) na[fidx] = 1;
                for (int i = 0; i < NB; i++) begin
                    m_act[a][i] <= na[i]; m_x[a][i] <= nx[i]; m_y[a][i] <= ny[i];
                end
                m_cd[a]    <= blk ? 0 : launch ? 6 : (m_cd[a] > 0 ? m_cd[a] - 1 : 0);
                m_pulse[a] <= launch;
                if (launch && m_shots[a] < 255) m_shots[a] <= m_shots[a] + 1;
                m_prev[a]  <= kd;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [NB-1:0]    ea;
        logic [10*NB-1:0] ex, ey;
        if (chk_en) begin
            for (int a = 0; a < 2; a++) begin
                for (int i = 0; i < NB; i++) begin
                    ea[i]          = m_act[a][i];
                    ex[10*i +: 10] = 10'(m_x[a][i]);
                    ey[10*i +: 10] = 10'(m_y[a][i]);
                end
                chk($sformatf("model_active[%0d]", a), 64'(act_o[a]), 64'(ea));
                chk($sformatf("model_X[%0d]", a), 64'(x_o[a]), 64'(ex));
                chk($sformatf("model_Y[%0d]", a), 64'(y_o[a]), 64'(ey));
                chk($sformatf("model_pulse[%0d]", a), 64'(pulse_o[a]), 64'(m_pulse[a]));
                chk($sformatf("model_shots[%0d]", a), 64'(shots_o[a]), 64'(m_shots[a]));
                chk($sformatf("size[%0d]", a), 64'(size_o[a]), 64'd3);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [10*NB-1:0] park_y;

    initial begin
        rst_n = 0; go = 0; ss = 0; sx = 10'd320; sy = 10'd400; key = '0; hit = '0;
        park_y = {4{10'd400}};
        tick(); tick();
        chk_en = 1;
        chk("reset_active", 64'(act_o[0]), 64'd0);
        chk("reset_X", 64'(x_o[0]), 64'd0);
        chk("reset_shots", 64'(shots_o[1]), 64'd0);
        rst_n = 1;
        tick();

        // Single press: launch then fly to the top.
        key = 24'h00002c; tick();
        chk("launch_active", 64'(act_o[0]), 64'b0001);
        chk("launch_X", 64'(x_o[0][9:0]), 64'd320);
        chk("launch_Y", 64'(y_o[0][9:0]), 64'd400);
        chk("launch_pulse", 64'(pulse_o[0]), 64'd1);
        chk("launch_shots", 64'(shots_o[0]), 64'd1);
        key = '0; tick();
        chk("fly_Y1", 64'(y_o[0][9:0]), 64'd392);
        chk("fly_pulse", 64'(pulse_o[0]), 64'd0);
        tick();
        chk("fly_Y2", 64'(y_o[0][9:0]), 64'd384);
        repeat (43) tick();
        chk("top_Y", 64'(y_o[0][9:0]), 64'd40);
        chk("top_active", 64'(act_o[0]), 64'b0001);
        tick();
        chk("retire_active", 64'(act_o[0]), 64'd0);
        chk("retire_park", 64'(y_o[0][9:0]), 64'd400);

        // Key held 20 frames: edge fires once, auto fires at 0,7,14.
        key = 24'h2c0000;
        repeat (20) tick();
        chk("hold_edge_shots", 64'(shots_o[0]), 64'd2);
        chk("hold_auto_shots", 64'(shots_o[1]), 64'd4);
        chk("hold_auto_active", 64'(act_o[1]), 64'b0111);
        chk("hold_edge_active", 64'(act_o[0]), 64'b0001);

        // game_over clears everything; key press during it does nothing.
        go = 1; key = 24'h002c00; tick();
        chk("go_active", 64'(act_o[0]), 64'd0);
        chk("go_park", 64'(y_o[0]), 64'(park_y));
        chk("go_pulse", 64'(pulse_o[1]), 64'd0);
        go = 0; key = '0; tick();

        // Fill the pool with spaced presses, then a fifth press is dropped.
        for (int p = 0; p < 4; p++) begin
            key = 24'h00002c; tick();
            key = '0; repeat (7) tick();
        end
        key = 24'h00002c; tick();
        chk("full_pulse", 64'(pulse_o[0]), 64'd0);
        chk("full_active", 64'(act_o[0]), 64'b1111);
        chk("full_shots", 64'(shots_o[0]), 64'd6);
        key = '0; tick();

        // Hit retires slot1; a press in the hit frame is ignored.
        hit = 4'b0010; key = 24'h00002c; tick();
        chk("hit_active", 64'(act_o[0]), 64'b1101);
        chk("hit_pulse", 64'(pulse_o[0]), 64'd0);
        chk("hit_park", 64'(y_o[0][19:10]), 64'd400);
        hit = '0; key = '0; tick();
        key = 24'h00002c; tick();
        chk("refill_active", 64'(act_o[0]), 64'b1111);
        chk("refill_pulse", 64'(pulse_o[0]), 64'd1);
        chk("refill_shots", 64'(shots_o[0]), 64'd7);

        // Reset mid-flight with key held, then fire on the first free frame.
        rst_n = 0; tick();
        chk("rst_active", 64'(act_o[0]), 64'd0);
        chk("rst_Y", 64'(y_o[0]), 64'd0);
        chk("rst_shots", 64'(shots_o[0]), 64'd0);
        rst_n = 1; tick();
        chk("rel_pulse", 64'(pulse_o[0]), 64'd1);
        chk("rel_active", 64'(act_o[0]), 64'b0001);
        key = '0; tick();

        // start_screen clears; ship at Y_MIN cannot fire, one pixel below can.
        ss = 1; tick();
        chk("ss_active", 64'(act_o[0]), 64'd0);
        ss = 0; tick();
        sy = 10'd30; key = 24'h00002c; tick();
        chk("ymin_pulse", 64'(pulse_o[0]), 64'd0);
        key = '0; tick();
        sy = 10'd31; key = 24'h00002c; tick();
        chk("ymin1_pulse", 64'(pulse_o[0]), 64'd1);
        key = '0; sy = 10'd400; tick();
        chk("low_retire", 64'(act_o[0]), 64'd0);

        // Saturation: retire every bullet immediately and keep firing.
        hit = '1;
        for (int n = 0; n < 2200; n++) begin
            key = 24'h00002c; tick();
            key = '0; tick();
        end
        chk("sat_edge", 64'(shots_o[0]), 64'd255);
        chk("sat_auto", 64'(shots_o[1]), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
